// File: rtl/fpnew_norm_pack.sv
// fpnew_norm_pack: two-stage normalizer/packer feeding the FPU rounding stage.
// Stage p1 finds the leading one and the normalized exponent. Stage p2 shifts
// the magnitude into place, builds the packed {exp, mantissa} value and the
// round/sticky pair, and encodes subnormal, overflow and zero results.
module fpnew_norm_pack #(
  parameter int unsigned ExpBits     = 8,
  parameter int unsigned ManBits     = 23,
  parameter int unsigned MantInWidth = 48,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       sign_i,
  input  logic [ExpBits+1:0]         exp_i,
  input  logic [MantInWidth-1:0]     mant_i,
  input  logic                       sticky_i,
  input  logic [2:0]                 rnd_mode_i,
  input  logic                       eff_sub_i,
  input  logic [TagWidth-1:0]        tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ExpBits+ManBits-1:0] abs_value_o,
  output logic [1:0]                 round_sticky_bits_o,
  output logic                       sign_o,
  output logic [2:0]                 rnd_mode_o,
  output logic                       eff_sub_o,
  output logic [TagWidth-1:0]        tag_o,
  output logic                       of_o,
  output logic                       tiny_o
);

  localparam int unsigned EW    = ExpBits + 2;            // input exponent width
  localparam int unsigned NW    = ExpBits + 3;            // normalized exponent width
  localparam int unsigned LZW   = $clog2(MantInWidth + 1);
  localparam int unsigned BW    = MantInWidth + 1;        // shift buffer width
  localparam int unsigned RSW   = $clog2(BW + 1);
  localparam int unsigned AW    = ExpBits + ManBits;
  localparam int unsigned FracW = MantInWidth - 1;        // bits below the hidden bit
  localparam int unsigned RestW = FracW - 1 - ManBits;    // bits below the round bit

  localparam logic signed [NW-1:0] ExpOne   = NW'(1);
  localparam logic signed [NW-1:0] MaxExp   = NW'((2 ** ExpBits) - 1);
  localparam logic signed [NW-1:0] ShiftSat = NW'(BW);

  // Leading-zero count; an all-zero input reports MantInWidth.
  function automatic logic [LZW-1:0] lzc(input logic [MantInWidth-1:0] v);
    lzc = LZW'(MantInWidth);
    for (int i = 0; i < MantInWidth; i++) begin
      if (v[i]) lzc = LZW'(MantInWidth - 1 - i);
    end
  endfunction

  // Largest finite magnitude: exponent field all-ones minus one, mantissa all-ones.
  function automatic logic [AW-1:0] max_finite();
    max_finite = {ExpBits'((2 ** ExpBits) - 2), {ManBits{1'b1}}};
  endfunction

  // Handshake: each stage may advance when its successor can take data.
  logic vld_p1_q, vld_p2_q;
  logic adv_p1, adv_p2;

  assign adv_p2     = ~vld_p2_q | out_ready_i;
  assign adv_p1     = ~vld_p1_q | adv_p2;
  assign in_ready_o = adv_p1;

  // ---- stage p1: leading-one detection and normalized exponent ----
  logic [LZW-1:0]         lzc_p1_d;
  logic signed [NW-1:0]   nexp_p1_d;

  assign lzc_p1_d  = lzc(mant_i);
  assign nexp_p1_d = $signed({exp_i[EW-1], exp_i}) + ExpOne
                   - $signed({{(NW-LZW){1'b0}}, lzc_p1_d});

  logic                   sign_p1_q, sticky_p1_q, eff_p1_q, zero_p1_q;
  logic [2:0]             rnd_p1_q;
  logic [TagWidth-1:0]    tag_p1_q;
  logic signed [EW-1:0]   exp_p1_q;
  logic [MantInWidth-1:0] mant_p1_q;
  logic [LZW-1:0]         lzc_p1_q;
  logic signed [NW-1:0]   nexp_p1_q;

  // Stage p1 register: captures inputs plus lzc/zero/exponent on advance.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_p1_q    <= 1'b0;
      sign_p1_q   <= 1'b0;
      sticky_p1_q <= 1'b0;
      eff_p1_q    <= 1'b0;
      zero_p1_q   <= 1'b0;
      rnd_p1_q    <= '0;
      tag_p1_q    <= '0;
      exp_p1_q    <= '0;
      mant_p1_q   <= '0;
      lzc_p1_q    <= '0;
      nexp_p1_q   <= '0;
    end else begin
      if (adv_p1) vld_p1_q <= in_valid_i;
      if (adv_p1 && in_valid_i) begin
        sign_p1_q   <= sign_i;
        sticky_p1_q <= sticky_i;
        eff_p1_q    <= eff_sub_i;
        zero_p1_q   <= (mant_i == '0);
        rnd_p1_q    <= rnd_mode_i;
        tag_p1_q    <= tag_i;
        exp_p1_q    <= $signed(exp_i);
        mant_p1_q   <= mant_i;
        lzc_p1_q    <= lzc_p1_d;
        nexp_p1_q   <= nexp_p1_d;
      end
    end
  end

  // ---- stage p2: shift, pack, special-case encoding ----
  logic                   normal, ovf, shout, rnd_bit, stk_bit;
  logic signed [NW-1:0]   exp_wide, neg_exp;
  logic [RSW-1:0]         rsh;
  logic [2*BW-1:0]        base, shw;
  logic [FracW-1:0]       frac;
  logic [ExpBits-1:0]     exp_field;
  logic [AW-1:0]          abs_d;
  logic [1:0]             rs_d;
  logic                   of_d, tiny_d;

  // Normal results shift by lzc; subnormals align to the minimum exponent,
  // which becomes a right shift (saturated) when the exponent is negative.
  // The lower half of the double-width buffer catches bits shifted out.
  always_comb begin
    normal   = (nexp_p1_q >= ExpOne);
    ovf      = (nexp_p1_q >= MaxExp);
    exp_wide = $signed({exp_p1_q[EW-1], exp_p1_q});
    neg_exp  = -exp_wide;
    rsh      = '0;
    base     = {1'b0, mant_p1_q, {BW{1'b0}}};
    if (normal) begin
      shw = base << lzc_p1_q;
    end else if (exp_p1_q[EW-1]) begin
      rsh = (neg_exp > ShiftSat) ? RSW'(BW) : RSW'(neg_exp);
      shw = base >> rsh;
    end else begin
      shw = base << exp_p1_q[LZW-1:0];
    end
    frac      = FracW'(shw >> BW);
    shout     = |shw[BW-1:0];
    rnd_bit   = frac[RestW];
    stk_bit   = (|frac[RestW-1:0]) | shout | sticky_p1_q;
    exp_field = normal ? nexp_p1_q[ExpBits-1:0] : '0;

    if (zero_p1_q) begin
      abs_d = '0;
      rs_d  = {1'b0, sticky_p1_q};
      of_d  = 1'b0;
    end else if (ovf) begin
      abs_d = max_finite();
      rs_d  = 2'b11;
      of_d  = 1'b1;
    end else begin
      abs_d = {exp_field, frac[FracW-1 -: ManBits]};
      rs_d  = {rnd_bit, stk_bit};
      of_d  = 1'b0;
    end
    tiny_d = (abs_d[AW-1 -: ExpBits] == '0) & (|rs_d);
  end

  logic                sign_p2_q, eff_p2_q, of_p2_q, tiny_p2_q;
  logic [2:0]          rnd_p2_q;
  logic [TagWidth-1:0] tag_p2_q;
  logic [AW-1:0]       abs_p2_q;
  logic [1:0]          rs_p2_q;

  // Stage p2 register: holds the packed result while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_p2_q  <= 1'b0;
      sign_p2_q <= 1'b0;
      eff_p2_q  <= 1'b0;
      of_p2_q   <= 1'b0;
      tiny_p2_q <= 1'b0;
      rnd_p2_q  <= '0;
      tag_p2_q  <= '0;
      abs_p2_q  <= '0;
      rs_p2_q   <= '0;
    end else begin
      if (adv_p2) vld_p2_q <= vld_p1_q;
      if (adv_p2 && vld_p1_q) begin
        sign_p2_q <= sign_p1_q;
        eff_p2_q  <= eff_p1_q;
        of_p2_q   <= of_d;
        tiny_p2_q <= tiny_d;
        rnd_p2_q  <= rnd_p1_q;
        tag_p2_q  <= tag_p1_q;
        abs_p2_q  <= abs_d;
        rs_p2_q   <= rs_d;
      end
    end
  end

  assign out_valid_o         = vld_p2_q;
  assign abs_value_o         = abs_p2_q;
  assign round_sticky_bits_o = rs_p2_q;
  assign sign_o              = sign_p2_q;
  assign rnd_mode_o          = rnd_p2_q;
  assign eff_sub_o           = eff_p2_q;
  assign tag_o               = tag_p2_q;
  assign of_o                = of_p2_q;
  assign tiny_o              = tiny_p2_q;

endmodule

// File: tb/tb_fpnew_norm_pack.sv
// Testbench for fpnew_norm_pack: directed vectors, scoreboard queue and an
// independent output monitor.
module tb_fpnew_norm_pack;

  localparam int ExpBits     = 8;
  localparam int ManBits     = 23;
  localparam int MantInWidth = 48;
  localparam int TagWidth    = 1;
  localparam int AW          = ExpBits + ManBits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i, flush_i, in_valid_i, in_ready_o;
  logic                   sign_i, sticky_i, eff_sub_i;
  logic [ExpBits+1:0]     exp_i;
  logic [MantInWidth-1:0] mant_i;
  logic [2:0]             rnd_mode_i;
  logic [TagWidth-1:0]    tag_i;
  logic                   out_valid_o, out_ready_i;
  logic [AW-1:0]          abs_value_o;
  logic [1:0]             round_sticky_bits_o;
  logic                   sign_o, eff_sub_o, of_o, tiny_o;
  logic [2:0]             rnd_mode_o;
  logic [TagWidth-1:0]    tag_o;

  fpnew_norm_pack #(
    .ExpBits(ExpBits), .ManBits(ManBits), .MantInWidth(MantInWidth), .TagWidth(TagWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .sticky_i(sticky_i),
    .rnd_mode_i(rnd_mode_i), .eff_sub_i(eff_sub_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .abs_value_o(abs_value_o), .round_sticky_bits_o(round_sticky_bits_o),
    .sign_o(sign_o), .rnd_mode_o(rnd_mode_o), .eff_sub_o(eff_sub_o),
    .tag_o(tag_o), .of_o(of_o), .tiny_o(tiny_o)
  );

  typedef struct packed {
    logic [AW-1:0]       abs;
    logic [1:0]          rs;
    logic                ovf;
    logic                tiny;
    logic                sign;
    logic [2:0]          rnd;
    logic                eff;
    logic [TagWidth-1:0] tag;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t dut_res();
    return {abs_value_o, round_sticky_bits_o, of_o, tiny_o, sign_o, rnd_mode_o, eff_sub_o, tag_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks that a stalled
  // output holds steady until it is taken.
  initial begin
    res_t cur, snap, expv;
    bit   have_snap;
    have_snap = 1'b0;
    snap      = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = dut_res();
      if (have_snap) begin
        checks++;
        if (!out_valid_o || cur !== snap) begin
          errors++;
          $display("FAIL stall_hold got=%h valid=%b required=%h", cur, out_valid_o, snap);
        end
      end
      have_snap = out_valid_o && !out_ready_i && !rst_i && !flush_i;
      snap      = cur;
      if (out_valid_o && out_ready_i && !rst_i && !flush_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h", cur);
        end else begin
          expv = sb_q.pop_front();
          if (cur !== expv) begin
            errors++;
            $display("FAIL result got=%h required=%h (abs got=%h req=%h)", cur, expv, cur.abs, expv.abs);
          end
        end
      end
    end
  end

  // Drive one op and push its expected result once it is accepted.
  task automatic send(input logic s, input int e, input logic [MantInWidth-1:0] m,
                      input logic st, input logic [2:0] rm, input logic ef,
                      input logic [TagWidth-1:0] tg, input logic [AW-1:0] ea,
                      input logic [1:0] ers, input logic eof, input logic etiny,
                      input bit push);
    int   waitc;
    res_t r;
    @(negedge clk);
    sign_i = s; exp_i = (ExpBits+2)'(e); mant_i = m; sticky_i = st;
    rnd_mode_i = rm; eff_sub_i = ef; tag_i = tg; in_valid_i = 1'b1;
    #1;
    waitc = 0;
    while (!in_ready_o && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 required=1");
      in_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      r = {ea, ers, eof, etiny, s, rm, ef, tg};
      if (push) sb_q.push_back(r);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({name, "_abs"}, 64'(abs_value_o), 64'd0);
    chk({name, "_misc"}, 64'({round_sticky_bits_o, of_o, tiny_o, sign_o, rnd_mode_o, eff_sub_o, tag_o}), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    sign_i = 1'b0; exp_i = '0; mant_i = '0; sticky_i = 1'b0;
    rnd_mode_i = '0; eff_sub_i = 1'b0; tag_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_cleared("reset");
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);

    // Directed vectors: sign, exp, mant, sticky, rnd, eff, tag -> abs, RS, of, tiny
    send(0, 127, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h3F80_0000, 2'b00, 0, 0, 1);
    send(0, 127, 48'h4000_0040_0000, 0, 3'd0, 0, 1'b1, 31'h3F80_0000, 2'b10, 0, 0, 1);
    send(0, 127, 48'h4000_0040_0000, 1, 3'd0, 0, 1'b0, 31'h3F80_0000, 2'b11, 0, 0, 1);
    send(0, -1,  48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0020_0000, 2'b00, 0, 0, 1);
    send(0, -30, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b1, 31'h0000_0000, 2'b01, 0, 1, 1);
    send(0, 300, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h7F7F_FFFF, 2'b11, 1, 0, 1);
    send(0, 300, 48'h0000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0000_0000, 2'b00, 0, 0, 1);
    send(0, 10,  48'h8000_0000_0000, 0, 3'd0, 0, 1'b1, 31'h0580_0000, 2'b00, 0, 0, 1);
    send(0, 254, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h7F00_0000, 2'b00, 0, 0, 1);
    send(0, 255, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h7F7F_FFFF, 2'b11, 1, 0, 1);
    send(0, 0,   48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0040_0000, 2'b00, 0, 0, 1);
    send(0, 1,   48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0080_0000, 2'b00, 0, 0, 1);
    send(0, -1,  48'h4000_0000_0001, 0, 3'd0, 0, 1'b0, 31'h0020_0000, 2'b01, 0, 1, 1);
    send(0, -512, 48'h8000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0000_0000, 2'b01, 0, 1, 1);
    send(0, -23, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h0000_0000, 2'b10, 0, 1, 1);
    send(0, 127, 48'h0000_0000_0001, 0, 3'd0, 0, 1'b0, 31'h2880_0000, 2'b00, 0, 0, 1);
    send(1, 127, 48'h6000_0000_0000, 0, 3'd4, 1, 1'b1, 31'h3FC0_0000, 2'b00, 0, 0, 1);
    send(0, 5,   48'h0000_0000_0000, 1, 3'd1, 0, 1'b0, 31'h0000_0000, 2'b01, 0, 1, 1);
    idle();
    drain();

    // Stream of 4 with the consumer stalled for several cycles mid-stream.
    out_ready_i = 1'b0;
    fork
      begin
        send(0, 127, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h3F80_0000, 2'b00, 0, 0, 1);
        send(0, 128, 48'h4000_0000_0000, 0, 3'd2, 0, 1'b1, 31'h4000_0000, 2'b00, 0, 0, 1);
        send(1, 129, 48'h4000_0000_0000, 0, 3'd3, 1, 1'b1, 31'h4080_0000, 2'b00, 0, 0, 1);
        send(0, 126, 48'h4000_0000_0000, 0, 3'd0, 0, 1'b0, 31'h3F00_0000, 2'b00, 0, 0, 1);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("stall_in_ready", 64'(in_ready_o), 64'd0);
        repeat (2) @(negedge clk);
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Flush with two ops held in the pipeline; they must never emerge.
    out_ready_i = 1'b0;
    send(1, 127, 48'h4000_0000_0000, 1, 3'd4, 1, 1'b1, 31'h3F80_0000, 2'b01, 0, 0, 0);
    send(1, 128, 48'h4000_0000_0000, 1, 3'd4, 1, 1'b1, 31'h4000_0000, 2'b01, 0, 0, 0);
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check_cleared("flush");
    out_ready_i = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with two ops held in the pipeline.
    out_ready_i = 1'b0;
    send(1, 129, 48'h4000_0000_0000, 1, 3'd3, 1, 1'b1, 31'h4080_0000, 2'b01, 0, 0, 0);
    send(1, 130, 48'h4000_0000_0000, 1, 3'd3, 1, 1'b1, 31'h4100_0000, 2'b01, 0, 0, 0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check_cleared("rst");
    out_ready_i = 1'b1;
    repeat (6) @(negedge clk);

    // Pipeline must work normally after recovery.
    send(0, 127, 48'h4000_0040_0000, 0, 3'd0, 0, 1'b1, 31'h3F80_0000, 2'b10, 0, 0, 1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
